// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted store FIFO between core store port and dmem, with load forwarding.
module dmem_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    input  logic [AW-1:0] cpu_raddr,
    output logic          fwd_hit,
    output logic [DW-1:0] fwd_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    output logic          empty,
    output logic          full
);
    localparam int PW = $clog2(DEPTH);
    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          enq, deq;
    assign empty     = count == '0;
    assign full      = count == (PW+1)'(DEPTH);
    assign enq       = cpu_we && !full;
    assign cpu_stall = cpu_we && full;
    assign mem_we    = !empty;
    assign deq       = mem_we && mem_ack;
    assign mem_addr  = addr_q[rd_ptr];
    assign mem_wdata = data_q[rd_ptr];
    always_ff @(posedge clk)
        if (enq) begin
            addr_q[wr_ptr] <= cpu_addr;
            data_q[wr_ptr] <= cpu_wdata;
        end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(enq);
            rd_ptr <= rd_ptr + PW'(deq);
            count  <= count + (PW+1)'(enq) - (PW+1)'(deq);
        end
    // Walk oldest to youngest so the last valid match is the youngest store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++)
            if ((PW+1)'(k) < count && addr_q[rd_ptr + PW'(k)][AW-1:2] == cpu_raddr[AW-1:2]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[rd_ptr + PW'(k)];
            end
    end
endmodule
